// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed seven-segment display (anodes active high).
// Latches a hex word plus enable/dp masks and cycles through enabled digits with a blanking gap.
module seg_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  output logic        load_ack,
  output logic [7:0]  an,
  output logic [3:0]  hex_nib,
  output logic        dp,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
  localparam int unsigned      BLANK_LAST_I = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_LAST_I);
  localparam bit               HAS_BLANK    = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_BLANK
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q;
  logic [7:0]       en_q;
  logic [7:0]       dp_q;
  logic             ack_q;
  logic [7:0]       an_q, an_d;
  logic [3:0]       nib_q, nib_d;
  logic             dpo_q, dpo_d;
  logic             fd_q, fd_d;

  logic [2:0]       nxt_idx, lo_idx, cand;
  logic             nxt_found, lo_found;
  logic             enter;
  logic [2:0]       enter_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      en_q   <= '0;
      dp_q   <= '0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= load;
      if (load) begin
        data_q <= data_in;
        en_q   <= digit_en;
        dp_q   <= dp_in;
      end
    end
  end

  // Search starts at idx+1 and wraps; idx itself is tried last so a lone digit repeats.
  always_comb begin
    cand      = '0;
    nxt_idx   = idx_q;
    nxt_found = 1'b0;
    lo_idx    = '0;
    lo_found  = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      cand = idx_q + 3'(k);
      if (!nxt_found && en_q[cand]) begin
        nxt_idx   = cand;
        nxt_found = 1'b1;
      end
    end
    for (int unsigned k = 0; k < 8; k++) begin
      if (!lo_found && en_q[3'(k)]) begin
        lo_idx   = 3'(k);
        lo_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    an_d      = an_q;
    nib_d     = nib_q;
    dpo_d     = dpo_q;
    fd_d      = 1'b0;
    enter     = 1'b0;
    enter_idx = idx_q;

    if (en_q == '0) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      an_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          enter     = 1'b1;
          enter_idx = lo_idx;
        end
        S_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            if (HAS_BLANK) begin
              state_d = S_BLANK;
              cnt_d   = '0;
              an_d    = '0;
            end else begin
              enter     = 1'b1;
              enter_idx = nxt_idx;
              fd_d      = (nxt_idx <= idx_q);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            enter     = 1'b1;
            enter_idx = nxt_idx;
            fd_d      = (nxt_idx <= idx_q);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          an_d    = '0;
        end
      endcase
    end

    // Nibble and dp are captured only here, so a reload never tears the lit digit.
    if (enter) begin
      state_d = S_SHOW;
      idx_d   = enter_idx;
      cnt_d   = '0;
      an_d    = 8'b1 << enter_idx;
      nib_d   = data_q[{enter_idx, 2'b00} +: 4];
      dpo_d   = dp_q[enter_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      an_q    <= '0;
      nib_q   <= '0;
      dpo_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      nib_q   <= nib_d;
      dpo_q   <= dpo_d;
      fd_q    <= fd_d;
    end
  end

  assign load_ack   = ack_q;
  assign an         = an_q;
  assign hex_nib    = nib_q;
  assign dp         = dpo_q;
  assign frame_done = fd_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for the EGO1 8-digit seven-segment display (two 4-digit groups, anodes active high). It latches a 32-bit hex word plus per-digit enable and decimal-point masks, then cycles through the enabled digits. For each digit it presents the 4-bit nibble to the downstream hex-to-seven-segment decoder and drives the matching one-hot anode. A blanking gap between digits suppresses ghosting.

Parameters:
DWELL_CYCLES, 100000, clock cycles each digit is lit (1 kHz per digit at 100 MHz); legal range >= 1
BLANK_CYCLES, 1000, clock cycles with all anodes off between digits; legal range >= 0 (0 = no gap)
CNT_W, 17, width of the internal dwell/blank counter; must hold max(DWELL_CYCLES, BLANK_CYCLES)-1

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous reset, active high
load  input  1  single-cycle request to latch data_in, digit_en and dp_in
data_in  input  32  hex word; digit i displays data_in[4i+3:4i]
digit_en  input  8  digit i is scanned when bit i = 1
dp_in  input  8  decimal point for digit i
load_ack  output  1  one-cycle pulse, the cycle after load is sampled
an  output  8  one-hot anode select, active high; all zero when blank or idle
hex_nib  output  4  nibble for the hex7seg decoder input
dp  output  1  decimal point of the currently lit digit, active high
frame_done  output  1  one-cycle pulse when the scan wraps from the highest enabled digit back to the lowest

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active high and overrides all other inputs.
- Reset values: an=0, hex_nib=0, dp=0, load_ack=0, frame_done=0, data_q=0, en_q=0, dp_q=0, idx=0, cnt=0, state=IDLE. The display stays dark until the first load.
- Shadow registers: when load=1 at edge N, data_q, en_q and dp_q take the input values and load_ack=1 during cycle N+1. A load is accepted in every state, and back-to-back loads are legal (last one wins).
- No tearing: the digit currently lit keeps its nibble and dp until its slot ends. New data appears at the next SHOW entry.
- Next-digit search is combinational over en_q. It starts at idx+1 and wraps 7->0. idx itself is checked last, so with one enabled digit the same digit repeats.
- All outputs are registered.
- State machine:
  - IDLE: an=0. If en_q != 0, go to SHOW with idx = lowest enabled digit and cnt=0.
  - SHOW: an=onehot(idx), hex_nib=data_q[4*idx+:4] and dp=dp_q[idx], all captured at entry. cnt increments each cycle.
    - At cnt=DWELL_CYCLES-1, go to BLANK with cnt=0 (if BLANK_CYCLES>0).
    - Otherwise go directly to SHOW on the next enabled digit.
  - BLANK: an=0; hex_nib and dp hold their values. At cnt=BLANK_CYCLES-1, go to SHOW on the next enabled digit.
  - Any state: if en_q==0 (after a load clears it), go to IDLE on the next edge. an=0 in the following cycle.
- Enable changes mid-slot: the next-digit choice uses en_q as it stands at the transition edge. A lit digit that has just been disabled finishes its slot.
- frame_done: asserted for one cycle coincident with entering SHOW on a digit whose index is <= the previous idx (a wrap). With a single enabled digit this is every slot.
- Latency: from load sampled in IDLE to the first anode lit is 2 cycles (latch, then IDLE->SHOW).
- Counter: wraps only through the state transitions and never exceeds its terminal value.
- Reset mid-scan: all outputs go to their reset values on the next edge, regardless of state.

Test Plan:
Use DWELL_CYCLES=4 and BLANK_CYCLES=1 unless stated otherwise.
1. Reset, no load, run 50 cycles -> an=0, hex_nib=0, dp=0 and frame_done=0 throughout.
2. Load data_in=32'h76543210, digit_en=8'hFF, dp_in=8'h01 -> load_ack at +1, an=8'h01 at +2 with hex_nib=0 and dp=1 for 4 cycles. Then an=0 for 1 cycle, then an=8'h02 with hex_nib=1 and dp=0. The sequence continues through 8'h80/hex_nib=7, then wraps to 8'h01 with frame_done=1.
3. digit_en=8'b1000_0101 -> anode order 8'h01, 8'h04, 8'h80, 8'h01..., with a blank gap between each and frame_done on every return to 8'h01.
4. Reload data_in=32'hFFFFFFFF mid-slot on digit 2 -> hex_nib stays 2 until the slot ends. Digit 3 then shows hex_nib=F.
5. Load digit_en=8'h00 while SHOW is active -> an=0 within 2 cycles of load and the state stays IDLE. A later load with 8'h10 lights an=8'h10 2 cycles after that load, and frame_done pulses every slot.
6. BLANK_CYCLES=0, digit_en=8'h03 -> an alternates 8'h01/8'h02 every 4 cycles with no zero gap. Asserting rst for 1 cycle mid-slot drives an=0 on the next cycle.
